// File: rtl/ahb_spi_master.sv
// ahb_spi_master
// AHB-Lite slave wrapping a single-master SPI controller (mode 0, MSB first,
// full duplex) with 32 software-driven slave-select lines.
//
// Ports
//   HCLK, HRESET          bus clock, synchronous active-high reset
//   HSEL, HREADY, HADDR,  AHB-Lite address phase (only HADDR[3:2] decoded,
//   HWRITE, HSIZE, HTRANS HSIZE ignored, HTRANS[1] marks a valid transfer)
//   HWDATA, HRDATA        data phase write / read data
//   HREADYOUT             always 1, zero wait states
//   SPI_MISO_i            serial data in, sampled on SCLK rising edges
//   SPI_MOSI_o            serial data out, changes on SCLK falling edges
//   SPI_SS_o              slave selects (pin level, active low)
//   SPI_CLK_o             SPI clock, idles low
//
// Register map: 0x0 CTRL/STATUS, 0x4 SS, 0x8 TXDATA, 0xC RXDATA.

module ahb_spi_master #(
  parameter int SCLK_DIV = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        SPI_MISO_i,
  output logic        SPI_MOSI_o,
  output logic [31:0] SPI_SS_o,
  output logic        SPI_CLK_o
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t        state;
  logic [1:0]    addr_q;
  logic          write_q;
  logic          valid_q;
  logic [2:0]    nbytes;
  logic          ssmode;
  logic [31:0]   ss_reg;
  logic [31:0]   tx_reg;
  logic [31:0]   tx_shift;
  logic [31:0]   rx_shift;
  logic [5:0]    bits_left;
  logic [5:0]    rx_count;
  logic          rx_full;
  logic          tx_done;
  logic [DW-1:0] div_cnt;
  logic          sclk;
  logic          mosi;

  logic          wr_en, rd_en, wr_ctrl, wr_ss, tx_start, rx_clear;
  logic          sclk_tick, sclk_rise, sclk_fall, busy;
  logic [2:0]    eff_bytes;
  logic [5:0]    pad_bits;
  logic [31:0]   tx_aligned;
  logic          unused_inputs;

  assign unused_inputs = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0]};

  assign HREADYOUT  = 1'b1;
  assign SPI_CLK_o  = sclk;
  assign SPI_MOSI_o = mosi;
  assign SPI_SS_o   = ssmode ? ~ss_reg : ss_reg;

  assign busy      = (state == ST_SHIFT);
  assign wr_en     = valid_q & write_q;
  assign rd_en     = valid_q & ~write_q;
  assign wr_ctrl   = wr_en && (addr_q == 2'd0);
  assign wr_ss     = wr_en && (addr_q == 2'd1);
  assign tx_start  = wr_en && (addr_q == 2'd2) && !busy;
  assign rx_clear  = rd_en && (addr_q == 2'd3);
  assign sclk_tick = busy && (div_cnt == DIV_LAST);
  assign sclk_rise = sclk_tick & ~sclk;
  assign sclk_fall = sclk_tick & sclk;

  // A length of 0 or anything above 4 means a full 32-bit word. The word is
  // left-aligned so byte NBYTES-1 leaves first from bit 31.
  assign eff_bytes  = ((nbytes == 3'd0) || (nbytes > 3'd4)) ? 3'd4 : nbytes;
  assign pad_bits   = {3'd4 - eff_bytes, 3'b000};
  assign tx_aligned = HWDATA << pad_bits;

  // Address phase capture; the data phase acts on these one cycle later.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q  <= 2'd0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= HADDR[3:2];
      write_q <= HWRITE;
      valid_q <= HSEL & HREADY & HTRANS[1];
    end
  end

  // Read data is driven only during a valid read data phase, otherwise zero.
  always_comb begin
    HRDATA = 32'd0;
    if (rd_en) begin
      case (addr_q)
        2'd0: begin
          HRDATA[0]     = rx_full;
          HRDATA[1]     = busy;
          HRDATA[4]     = tx_done;
          HRDATA[6]     = ssmode;
          HRDATA[14:12] = nbytes;
        end
        2'd1:    HRDATA = ss_reg;
        2'd2:    HRDATA = tx_reg;
        default: HRDATA = rx_shift;
      endcase
    end
  end

  // Registers, transfer FSM and receive bookkeeping. Clears from an RXDATA
  // read or TXDATA write are placed last so they win over same-cycle sets.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      nbytes    <= 3'd0;
      ssmode    <= 1'b1;
      ss_reg    <= 32'd0;
      tx_reg    <= 32'd0;
      tx_shift  <= 32'd0;
      rx_shift  <= 32'd0;
      bits_left <= 6'd0;
      rx_count  <= 6'd0;
      rx_full   <= 1'b0;
      tx_done   <= 1'b0;
      div_cnt   <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        nbytes <= HWDATA[14:12];
        ssmode <= HWDATA[6];
      end
      if (wr_ss) ss_reg <= HWDATA;
      if (sclk_rise) rx_shift <= {rx_shift[30:0], SPI_MISO_i};

      case (state)
        ST_SHIFT: begin
          if (sclk_tick) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (sclk_rise) bits_left <= bits_left - 6'd1;
          // The falling edge after the last rising edge only parks SCLK low;
          // MOSI keeps the final bit.
          if (sclk_fall) begin
            if (bits_left == 6'd0) begin
              state   <= ST_DONE;
              tx_done <= 1'b1;
            end else begin
              mosi     <= tx_shift[31];
              tx_shift <= tx_shift << 1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          if (tx_start) begin
            state     <= ST_SHIFT;
            tx_reg    <= HWDATA;
            mosi      <= tx_aligned[31];
            tx_shift  <= tx_aligned << 1;
            bits_left <= {eff_bytes, 3'b000};
            div_cnt   <= '0;
            sclk      <= 1'b0;
          end
        end
      endcase

      // Received bit count saturates at 32 and flags RX_FULL on reaching it.
      if (rx_clear) begin
        rx_count <= 6'd0;
        rx_full  <= 1'b0;
      end else if (sclk_rise && (rx_count != 6'd32)) begin
        rx_count <= rx_count + 6'd1;
        if (rx_count == 6'd31) rx_full <= 1'b1;
      end

      if (tx_start || rx_clear) tx_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_spi_master.sv
// tb_ahb_spi_master
// Self-checking bench for ahb_spi_master. A behavioural model tracks the
// register contents, the received bit stream and the expected MOSI stream;
// the SPI side is driven/observed by a simple slave process.

module tb_ahb_spi_master;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        SPI_MISO_i;
  logic        SPI_MOSI_o;
  logic [31:0] SPI_SS_o;
  logic        SPI_CLK_o;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [2:0]  m_nbytes;
  logic        m_ssmode;
  logic        m_txdone;
  int          m_cnt;
  logic [31:0] m_rx;

  logic        miso_q[$];
  logic        mosi_seen[$];
  bit          measure = 0;
  longint      t_rise = 0;
  int          hp_min = 1000000;
  int          hp_max = 0;

  ahb_spi_master #(.SCLK_DIV(8)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSEL       (HSEL),
    .HREADY     (HREADY),
    .HADDR      (HADDR),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HTRANS     (HTRANS),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADYOUT  (HREADYOUT),
    .SPI_MISO_i (SPI_MISO_i),
    .SPI_MOSI_o (SPI_MOSI_o),
    .SPI_SS_o   (SPI_SS_o),
    .SPI_CLK_o  (SPI_CLK_o)
  );

  // 10-unit bus clock
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // SPI slave: after each SCLK rising edge record MOSI and present the next
  // MISO bit well before the following rising edge.
  initial begin
    forever begin
      @(posedge SPI_CLK_o);
      t_rise = longint'($time);
      #1;
      mosi_seen.push_back(SPI_MOSI_o);
      if (miso_q.size() > 0) void'(miso_q.pop_front());
      SPI_MISO_i = (miso_q.size() > 0) ? miso_q[0] : 1'b0;
    end
  end

  // High-phase width of SCLK, in simulation time units.
  initial begin
    forever begin
      @(negedge SPI_CLK_o);
      if (measure) begin
        int d;
        d = int'(longint'($time) - t_rise);
        if (d < hp_min) hp_min = d;
        if (d > hp_max) hp_max = d;
      end
    end
  end

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic int effBytes(input logic [2:0] n);
    return ((n == 3'd0) || (n > 3'd4)) ? 4 : int'(n);
  endfunction

  function automatic logic [31:0] expStatus(input logic busyBit);
    logic [31:0] s;
    s = 32'd0;
    s[14:12] = m_nbytes;
    s[6]     = m_ssmode;
    s[4]     = m_txdone;
    s[1]     = busyBit;
    s[0]     = (m_cnt >= 32);
    return s;
  endfunction

  task automatic ahbWrite(input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] size);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr; HSIZE = size;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0; HWDATA = data;
    @(posedge HCLK);
    #1;
  endtask

  task automatic ahbRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr; HSIZE = 3'b010;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'd0;
    data = HRDATA;
    @(posedge HCLK);
    #1;
  endtask

  task automatic waitIdle(output logic [31:0] st, output logic timedOut);
    timedOut = 1'b1;
    st = 32'd0;
    for (int i = 0; i < 600; i++) begin
      ahbRead(32'h0, st);
      if (!st[1]) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  // Queue the low nbits of bits (MSB first) for MISO and fold them into the
  // expected receive register.
  task automatic loadMiso(input logic [31:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      miso_q.push_back(bits[i]);
      m_rx = {m_rx[30:0], bits[i]};
    end
    SPI_MISO_i = miso_q[0];
  endtask

  // One complete transfer using the current NBYTES, checked end to end.
  task automatic applyStimulus(input logic [31:0] tx, input logic [31:0] misoBits,
                               input logic [2:0] size, input bit pokeBusy);
    int          n;
    int          nbits;
    logic [31:0] st;
    logic [31:0] obs;
    logic [31:0] mask;
    logic        to;
    n     = effBytes(m_nbytes);
    nbits = 8 * n;
    mask  = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << nbits) - 32'h1);
    loadMiso(misoBits, nbits);
    mosi_seen.delete();
    ahbWrite(32'h8, tx, size);
    m_txdone = 1'b0;
    ahbRead(32'h0, st);
    checkOutput("status_busy", st, expStatus(1'b1));
    if (pokeBusy) ahbWrite(32'h8, ~tx, 3'b010);
    waitIdle(st, to);
    checkOutput("done_wait_timeout", {31'd0, to}, 32'd0);
    m_txdone = 1'b1;
    m_cnt = (m_cnt + nbits > 32) ? 32 : m_cnt + nbits;
    checkOutput("status_done", st, expStatus(1'b0));
    obs = 32'd0;
    foreach (mosi_seen[i]) obs = {obs[30:0], mosi_seen[i]};
    checkOutput("mosi_bits", obs, tx & mask);
    checkOutput("sclk_rises", 32'(mosi_seen.size()), 32'(nbits));
    checkOutput("mosi_hold", {31'd0, SPI_MOSI_o}, {31'd0, tx[0]});
    if (!pokeBusy) begin
      ahbRead(32'h8, st);
      checkOutput("txdata_read", st, tx);
    end
  endtask

  task automatic readRx();
    logic [31:0] v;
    ahbRead(32'hC, v);
    checkOutput("rxdata", v, m_rx);
    m_cnt = 0;
    m_txdone = 1'b0;
    ahbRead(32'h0, v);
    checkOutput("status_after_rx", v, expStatus(1'b0));
  endtask

  initial begin
    logic [31:0] v;
    logic        to;

    HRESET = 1'b1; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0; HTRANS = 2'b00;
    HSIZE = 3'b010; HADDR = 32'd0; HWDATA = 32'd0; SPI_MISO_i = 1'b0;
    m_nbytes = 3'd0; m_ssmode = 1'b1; m_txdone = 1'b0; m_cnt = 0; m_rx = 32'd0;

    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    checkOutput("hrdata_reset", HRDATA, 32'd0);
    checkOutput("sclk_reset", {31'd0, SPI_CLK_o}, 32'd0);
    checkOutput("mosi_reset", {31'd0, SPI_MOSI_o}, 32'd0);
    checkOutput("ss_reset", SPI_SS_o, 32'hFFFF_FFFF);
    checkOutput("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    ahbRead(32'h0, v);
    checkOutput("ctrl_reset", v, expStatus(1'b0));
    measure = 1;

    // Select slave 0, two-byte transfers, active-low selects
    ahbWrite(32'h0, 32'h0000_2040, 3'b010);
    m_nbytes = 3'd2; m_ssmode = 1'b1;
    ahbWrite(32'h4, 32'h0000_0001, 3'b010);
    checkOutput("ss_pins_slave0", SPI_SS_o, 32'hFFFF_FFFE);
    ahbRead(32'h0, v);
    checkOutput("ctrl_read", v, 32'h0000_2040);

    // Two 2-byte transfers with MISO stream 0x01 02 03 04
    applyStimulus(32'h0000_1308, 32'h0000_0102, 3'b001, 1'b1);
    applyStimulus(32'h0000_5AC3, 32'h0000_0304, 3'b010, 1'b0);
    ahbRead(32'h0, v);
    checkOutput("rx_full_set", {31'd0, v[0]}, 32'd1);
    readRx();

    // NBYTES=0 means a full 32-bit transfer
    ahbWrite(32'h0, 32'h0000_0040, 3'b010);
    m_nbytes = 3'd0;
    applyStimulus(32'hA5C3_0F81, $urandom, 3'b010, 1'b0);
    readRx();

    // Randomised lengths, select modes and data
    for (int it = 0; it < 8; it++) begin
      logic [31:0] junk;
      logic [31:0] ssv;
      logic [2:0]  nb;
      logic        sm;
      nb = 3'($urandom_range(0, 7));
      sm = 1'($urandom_range(0, 1));
      junk = $urandom;
      junk[14:12] = nb;
      junk[6] = sm;
      ahbWrite(32'h0, junk, 3'b010);
      m_nbytes = nb; m_ssmode = sm;
      ssv = $urandom;
      ahbWrite(32'h4, ssv, 3'b010);
      checkOutput("ss_pins", SPI_SS_o, sm ? ~ssv : ssv);
      ahbRead(32'h4, v);
      checkOutput("ss_read", v, ssv);
      ahbRead(32'h0, v);
      checkOutput("ctrl_read_rand", v, expStatus(1'b0));
      applyStimulus($urandom, $urandom, 3'($urandom_range(0, 2)), 1'b0);
      if ($urandom_range(0, 1) == 1) readRx();
    end

    checkOutput("sclk_half_min", 32'(hp_min), 32'd80);
    checkOutput("sclk_half_max", 32'(hp_max), 32'd80);
    measure = 0;

    // Abort a 32-bit transfer with reset while SCLK is high
    ahbWrite(32'h0, 32'h0000_4040, 3'b010);
    ahbWrite(32'h8, $urandom, 3'b010);
    to = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge HCLK);
      if (SPI_CLK_o) begin
        to = 1'b0;
        break;
      end
    end
    checkOutput("sclk_high_wait_timeout", {31'd0, to}, 32'd0);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    checkOutput("sclk_after_reset", {31'd0, SPI_CLK_o}, 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    miso_q.delete();
    SPI_MISO_i = 1'b0;
    m_nbytes = 3'd0; m_ssmode = 1'b1; m_txdone = 1'b0; m_cnt = 0; m_rx = 32'd0;
    checkOutput("ss_after_reset", SPI_SS_o, 32'hFFFF_FFFF);
    ahbRead(32'h0, v);
    checkOutput("status_after_abort", v, expStatus(1'b0));
    ahbRead(32'hC, v);
    checkOutput("rx_after_abort", v, m_rx);
    repeat (40) @(negedge HCLK);
    checkOutput("sclk_idle_after_abort", {31'd0, SPI_CLK_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
